timer_host_master: RTL and testbench

- Avalon-MM master that drives the interval-timer slave: 16-bit data, 4-bit word address, single-cycle writes, registered readdata.
- Turns single-beat commands from local control logic into the timer's register sequences: 64-bit period load, start/stop, snapshot read-back, status read and status clear.
- Returns one response per command and reports timer timeouts as a one-cycle pulse.
- Sits between the decoder's frame-pacing logic and the timer slave on the same clock.

---
 rtl/timer_host_master_if.sv | 44 ++++
 rtl/timer_host_master.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_timer_host_master.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_host_master_if.sv
// rtl/timer_host_master_if.sv - command/response and Avalon-MM signal bundle for timer_host_master
//
// Purpose: groups the local command/response handshake and the Avalon-MM
// master bus of timer_host_master into one interface.
// Modports:
//   master - the timer host master side (drives cmd_ready, rsp_*, m_* bus outputs)
//   slave  - the opposite side (command source, response sink, timer slave)
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_ctrl - single-beat command
//   rsp_valid/rsp_data/rsp_error                 - one-cycle response
//   m_address/m_chipselect/m_write_n/m_writedata - Avalon-MM requests
//   m_readdata                                   - Avalon-MM read data (one cycle after address)

interface timer_host_master_if #(
  parameter int ADDR_W = 4,
  parameter int HW     = 16,
  parameter int NUM_HW = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [HW*NUM_HW-1:0] cmd_data;
  logic [1:0]           cmd_ctrl;
  logic                 rsp_valid;
  logic [HW*NUM_HW-1:0] rsp_data;
  logic                 rsp_error;
  logic [ADDR_W-1:0]    m_address;
  logic                 m_chipselect;
  logic                 m_write_n;
  logic [HW-1:0]        m_writedata;
  logic [HW-1:0]        m_readdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, cmd_ctrl, m_readdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_error,
           m_address, m_chipselect, m_write_n, m_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, cmd_ctrl, m_readdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error,
           m_address, m_chipselect, m_write_n, m_writedata
  );
endinterface

// File: rtl/timer_host_master.sv
// rtl/timer_host_master.sv - Avalon-MM master sequencing interval-timer register accesses
//
// Purpose: converts single-beat local commands (LOAD, START, STOP, SNAP,
// STATUS, CLEAR, RDPER) into the timer slave's register write/read sequences,
// returns one response per command and turns rising edges of the timer irq
// into a one-cycle timeout pulse.
// Optional build macro: TIMER_HOST_AUTO_CLEAR_EN - after each irq rising edge
// the master issues one internal status-clear write (addr 0, data 0) with no
// response, holding off new commands until it has been issued.
// Ports:
//   clk             - clock
//   reset_n         - asynchronous active-low reset
//   bus             - timer_host_master_if.master (command, response, Avalon-MM)
//   i_irq_in        - timer irq, same clock domain
//   o_timeout_pulse - one cycle high after each rising edge of i_irq_in

module timer_host_master #(
  parameter int ADDR_W = 4,
  parameter int HW     = 16,
  parameter int NUM_HW = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  timer_host_master_if.master bus,
  input  logic                i_irq_in,
  output logic                o_timeout_pulse
);
  localparam int PAY_W = HW * NUM_HW;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_START  = 3'd1;
  localparam logic [2:0] OP_STOP   = 3'd2;
  localparam logic [2:0] OP_SNAP   = 3'd3;
  localparam logic [2:0] OP_STATUS = 3'd4;
  localparam logic [2:0] OP_CLEAR  = 3'd5;
  localparam logic [2:0] OP_RDPER  = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_CAP  = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_beat;
  logic [1:0]        w_beat_nxt;
  logic              r_auto;       // current WR beat is the internal status clear
  logic              w_auto_nxt;

  logic [2:0]        r_op;
  logic [PAY_W-1:0]  r_data;
  logic [1:0]        r_ctrl;

  logic [ADDR_W-1:0] r_m_address;
  logic              r_m_chipselect;
  logic              r_m_write_n;
  logic [HW-1:0]     r_m_writedata;
  logic [ADDR_W-1:0] w_m_address_nxt;
  logic              w_m_chipselect_nxt;
  logic              w_m_write_n_nxt;
  logic [HW-1:0]     w_m_writedata_nxt;

  logic              r_rsp_valid;
  logic [PAY_W-1:0]  r_rsp_data;
  logic              r_rsp_error;

  logic              r_irq_q;
  logic              r_timeout_pulse;

  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_irq_rise;
  logic              w_clr_req;
  logic              w_last_beat;
  logic [2:0]        w_op_eff;
  logic [PAY_W-1:0]  w_data_eff;
  logic [1:0]        w_ctrl_eff;

  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_irq_rise  = i_irq_in && !r_irq_q;
  assign w_last_beat = (r_beat == 2'(NUM_HW - 1));

  // Bus outputs are registered from the next state, so the beat for the
  // accept cycle has to see the command inputs rather than the latches.
  assign w_op_eff   = w_accept ? bus.cmd_op   : r_op;
  assign w_data_eff = w_accept ? bus.cmd_data : r_data;
  assign w_ctrl_eff = w_accept ? bus.cmd_ctrl : r_ctrl;

`ifdef TIMER_HOST_AUTO_CLEAR_EN
  logic r_clr_pending;

  assign w_cmd_ready = (r_state == S_IDLE) && !r_clr_pending;
  // An edge seen in the RESP cycle itself still gets the clear slotted in
  // ahead of the next accept.
  assign w_clr_req   = r_clr_pending || w_irq_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_pending <= 1'b0;
    end else if (w_irq_rise) begin
      r_clr_pending <= 1'b1;
    end else if (r_state == S_WR && r_auto) begin
      r_clr_pending <= 1'b0;
    end
  end
`else
  assign w_cmd_ready = (r_state == S_IDLE);
  assign w_clr_req   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
      r_auto  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_auto  <= w_auto_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_auto_nxt  = r_auto;
    case (r_state)
      S_IDLE: begin
        w_beat_nxt = 2'd0;
        w_auto_nxt = 1'b0;
        if (w_accept) begin
          case (bus.cmd_op)
            OP_STATUS, OP_RDPER: w_state_nxt = S_RD_ADDR;
            OP_RSVD:             w_state_nxt = S_RESP;
            default:             w_state_nxt = S_WR;
          endcase
        end else if (w_clr_req) begin
          w_state_nxt = S_WR;
          w_auto_nxt  = 1'b1;
        end
      end
      S_WR: begin
        if (r_auto) begin
          w_state_nxt = S_IDLE;
          w_auto_nxt  = 1'b0;
        end else begin
          case (r_op)
            OP_LOAD: begin
              if (w_last_beat) begin
                w_state_nxt = S_RESP;
              end else begin
                w_beat_nxt = r_beat + 2'd1;
              end
            end
            // Snapshot latch write done; read the captured value back.
            OP_SNAP: begin
              w_state_nxt = S_RD_ADDR;
              w_beat_nxt  = 2'd0;
            end
            default: w_state_nxt = S_RESP;
          endcase
        end
      end
      S_RD_ADDR: w_state_nxt = S_RD_CAP;
      S_RD_CAP: begin
        if (r_op == OP_STATUS || w_last_beat) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_RD_ADDR;
          w_beat_nxt  = r_beat + 2'd1;
        end
      end
      S_RESP: begin
        w_beat_nxt = 2'd0;
        if (w_clr_req) begin
          w_state_nxt = S_WR;
          w_auto_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_beat_nxt  = 2'd0;
        w_auto_nxt  = 1'b0;
      end
    endcase
  end

  // Output logic: bus values for the cycle that the next state occupies
  always_comb begin
    w_m_address_nxt    = '0;
    w_m_chipselect_nxt = 1'b0;
    w_m_write_n_nxt    = 1'b1;
    w_m_writedata_nxt  = '0;
    case (w_state_nxt)
      S_WR: begin
        w_m_chipselect_nxt = 1'b1;
        w_m_write_n_nxt    = 1'b0;
        if (!w_auto_nxt) begin
          case (w_op_eff)
            OP_LOAD: begin
              w_m_address_nxt   = ADDR_W'(2) + ADDR_W'(w_beat_nxt);
              w_m_writedata_nxt = w_data_eff[{w_beat_nxt, 4'b0000} +: HW];
            end
            // Control register: bit3 stop, bit2 start, bits1:0 {continuous, irq_enable}
            OP_START: begin
              w_m_address_nxt   = ADDR_W'(1);
              w_m_writedata_nxt = {{(HW-4){1'b0}}, 2'b01, w_ctrl_eff};
            end
            OP_STOP: begin
              w_m_address_nxt   = ADDR_W'(1);
              w_m_writedata_nxt = {{(HW-4){1'b0}}, 2'b10, w_ctrl_eff};
            end
            OP_SNAP:  w_m_address_nxt = ADDR_W'(6);
            default:  w_m_address_nxt = '0;
          endcase
        end
      end
      S_RD_ADDR: begin
        w_m_chipselect_nxt = 1'b1;
        case (w_op_eff)
          OP_SNAP:  w_m_address_nxt = ADDR_W'(6) + ADDR_W'(w_beat_nxt);
          OP_RDPER: w_m_address_nxt = ADDR_W'(2) + ADDR_W'(w_beat_nxt);
          default:  w_m_address_nxt = '0;
        endcase
      end
      default: ;
    endcase
  end

  // Registered bus, response, latches and irq edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op            <= 3'd0;
      r_data          <= '0;
      r_ctrl          <= 2'd0;
      r_m_address     <= '0;
      r_m_chipselect  <= 1'b0;
      r_m_write_n     <= 1'b1;
      r_m_writedata   <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= '0;
      r_rsp_error     <= 1'b0;
      r_irq_q         <= 1'b0;
      r_timeout_pulse <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= bus.cmd_op;
        r_data <= bus.cmd_data;
        r_ctrl <= bus.cmd_ctrl;
      end

      r_m_address    <= w_m_address_nxt;
      r_m_chipselect <= w_m_chipselect_nxt;
      r_m_write_n    <= w_m_write_n_nxt;
      r_m_writedata  <= w_m_writedata_nxt;

      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_rsp_error <= (w_state_nxt == S_RESP) && (w_op_eff == OP_RSVD);

      // readdata belongs to the address driven in the previous (RD_ADDR) cycle.
      if (w_accept) begin
        r_rsp_data <= '0;
      end else if (r_state == S_RD_CAP) begin
        if (r_op == OP_STATUS) begin
          r_rsp_data[{r_beat, 4'b0000} +: HW] <= {{(HW-2){1'b0}}, bus.m_readdata[1:0]};
        end else begin
          r_rsp_data[{r_beat, 4'b0000} +: HW] <= bus.m_readdata;
        end
      end

      r_irq_q         <= i_irq_in;
      r_timeout_pulse <= w_irq_rise;
    end
  end

  assign bus.cmd_ready    = w_cmd_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_error    = r_rsp_error;
  assign bus.m_address    = r_m_address;
  assign bus.m_chipselect = r_m_chipselect;
  assign bus.m_write_n    = r_m_write_n;
  assign bus.m_writedata  = r_m_writedata;
  assign o_timeout_pulse  = r_timeout_pulse;

endmodule

// File: tb/tb_timer_host_master.sv
// tb/tb_timer_host_master.sv - directed scoreboard bench for timer_host_master

module tb_timer_host_master;

  typedef struct packed {
    int          c;
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  typedef struct packed {
    int          c;
    logic [63:0] d;
    logic        e;
  } rs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq_in = 1'b0;
  logic timeout_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  wr_t wr_log[$];
  wr_t exp_wr[$];
  rs_t rsp_log[$];
  rs_t exp_rsp[$];
  int  tp_log[$];

  timer_host_master_if bus();

  timer_host_master dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus.master),
    .i_irq_in        (irq_in),
    .o_timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave model
  logic [15:0] sl_per  [4] = '{default: 16'h0};
  logic [15:0] sl_snap [4] = '{default: 16'h0};
  logic        sl_run = 1'b0;
  logic        sl_to  = 1'b0;
  logic [15:0] sl_rd  = 16'h0;
  logic [63:0] snap_src = 64'h0;
  logic        tb_set_to = 1'b0;

  function automatic logic [15:0] sl_read(input logic [3:0] a);
    case (a)
      4'd0:                 return {14'b0, sl_run, sl_to};
      4'd2, 4'd3, 4'd4, 4'd5: return sl_per[2'(a - 4'd2)];
      4'd6, 4'd7, 4'd8, 4'd9: return sl_snap[2'(a - 4'd6)];
      default:              return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clk) begin
    if (tb_set_to) sl_to <= 1'b1;
    if (bus.m_chipselect && !bus.m_write_n) begin
      case (bus.m_address)
        4'd0: sl_to <= 1'b0;
        4'd1: begin
          if (bus.m_writedata[2]) sl_run <= 1'b1;
          if (bus.m_writedata[3]) sl_run <= 1'b0;
        end
        4'd2, 4'd3, 4'd4, 4'd5: begin
          sl_per[2'(bus.m_address - 4'd2)] <= bus.m_writedata;
          sl_run <= 1'b0;
        end
        4'd6: begin
          for (int i = 0; i < 4; i++) sl_snap[i] <= snap_src[16*i +: 16];
        end
        default: ;
      endcase
    end
    if (bus.m_chipselect && bus.m_write_n) sl_rd <= sl_read(bus.m_address);
  end

  assign bus.m_readdata = sl_rd;

  // Monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.m_chipselect && !bus.m_write_n)
        wr_log.push_back('{cyc, bus.m_address, bus.m_writedata});
      if (bus.rsp_valid)
        rsp_log.push_back('{cyc, bus.rsp_data, bus.rsp_error});
      if (timeout_pulse)
        tp_log.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic void push_exp_writes(input logic [2:0] op, input logic [63:0] d,
                                          input logic [1:0] c, input int a);
    case (op)
      3'd0: for (int i = 0; i < 4; i++) exp_wr.push_back('{a + 1 + i, 4'(2 + i), d[16*i +: 16]});
      3'd1: exp_wr.push_back('{a + 1, 4'd1, {12'b0, 2'b01, c}});
      3'd2: exp_wr.push_back('{a + 1, 4'd1, {12'b0, 2'b10, c}});
      3'd3: exp_wr.push_back('{a + 1, 4'd6, 16'h0000});
      3'd5: exp_wr.push_back('{a + 1, 4'd0, 16'h0000});
      default: ;
    endcase
  endfunction

  // Drive a command, return its accept cycle, then scramble inputs to prove latching.
  task automatic issue(input logic [2:0] op, input logic [63:0] d, input logic [1:0] c,
                       output int a);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_ctrl  = c;
    n = 0;
    while (!bus.cmd_ready && n < 40) begin
      step();
      n++;
    end
    if (!bus.cmd_ready) chk("accept_timeout", 64'(bus.cmd_ready), 64'd1);
    a = cyc;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd7;
    bus.cmd_data  = {$urandom, $urandom};
    bus.cmd_ctrl  = ~c;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 40 && rsp_log.size() == 0; i++) step();
    chk("rsp_seen", 64'(rsp_log.size() != 0), 64'd1);
  endtask

  task automatic check_rsp();
    rs_t o;
    rs_t e;
    if (rsp_log.size() != 0 && exp_rsp.size() != 0) begin
      o = rsp_log.pop_front();
      e = exp_rsp.pop_front();
      chk("rsp_cycle", 64'(o.c), 64'(e.c));
      chk("rsp_data",  o.d, e.d);
      chk("rsp_error", 64'(o.e), 64'(e.e));
    end
  endtask

  task automatic check_writes();
    wr_t o;
    wr_t e;
    chk("wr_count", 64'(wr_log.size()), 64'(exp_wr.size()));
    while (wr_log.size() != 0 && exp_wr.size() != 0) begin
      o = wr_log.pop_front();
      e = exp_wr.pop_front();
      chk("wr_beat", 64'(o), 64'(e));
    end
    wr_log.delete();
    exp_wr.delete();
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [63:0] d, input logic [1:0] c,
                         input int lat, input logic [63:0] exp_d, input logic exp_e);
    int a;
    issue(op, d, c, a);
    exp_rsp.push_back('{a + lat, exp_d, exp_e});
    push_exp_writes(op, d, c, a);
    wait_rsp();
    check_rsp();
    chk("ready_in_resp", 64'(bus.cmd_ready), 64'd0);
    step();
    chk("ready_after_resp", 64'(bus.cmd_ready), 64'd1);
    step();
    check_writes();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 64'h0;
    bus.cmd_ctrl  = 2'b00;

    repeat (3) step();
    chk("rst_cmd_ready",  64'(bus.cmd_ready),    64'd1);
    chk("rst_chipselect", 64'(bus.m_chipselect), 64'd0);
    chk("rst_write_n",    64'(bus.m_write_n),    64'd1);
    chk("rst_address",    64'(bus.m_address),    64'd0);
    chk("rst_writedata",  64'(bus.m_writedata),  64'd0);
    chk("rst_rsp_valid",  64'(bus.rsp_valid),    64'd0);
    chk("rst_rsp_data",   bus.rsp_data,          64'd0);
    chk("rst_rsp_error",  64'(bus.rsp_error),    64'd0);
    chk("rst_timeout",    64'(timeout_pulse),    64'd0);
    reset_n = 1'b1;
    step();

    run_cmd(3'd0, 64'h0000_0001_0002_0003, 2'b00, 5, 64'h0, 1'b0);          // LOAD
    run_cmd(3'd6, 64'h0, 2'b00, 9, 64'h0000_0001_0002_0003, 1'b0);          // RDPER
    run_cmd(3'd1, 64'h0, 2'b11, 2, 64'h0, 1'b0);                            // START -> 0007

    tb_set_to = 1'b1;
    step();
    tb_set_to = 1'b0;
    run_cmd(3'd4, 64'h0, 2'b00, 3, 64'h3, 1'b0);                            // STATUS running+timeout
    run_cmd(3'd5, 64'h0, 2'b00, 2, 64'h0, 1'b0);                            // CLEAR
    run_cmd(3'd4, 64'h0, 2'b00, 3, 64'h2, 1'b0);                            // STATUS running only

    snap_src = 64'h1122_3344_5566_7788;
    run_cmd(3'd3, 64'h0, 2'b00, 10, 64'h1122_3344_5566_7788, 1'b0);         // SNAP
    chk("rsp_data_hold", bus.rsp_data, 64'h1122_3344_5566_7788);

    run_cmd(3'd2, 64'h0, 2'b01, 2, 64'h0, 1'b0);                            // STOP -> 0009
    run_cmd(3'd4, 64'h0, 2'b00, 3, 64'h0, 1'b0);                            // STATUS idle
    run_cmd(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1, 64'h0, 1'b1);          // reserved

    // Reset during the third read beat of RDPER
    issue(3'd6, 64'h0, 2'b00, a);
    for (int i = 0; i < 20 && cyc < a + 5; i++) step();
    chk("rdper_beat2_addr", 64'(bus.m_address), 64'd4);
    reset_n = 1'b0;
    #1;
    chk("midrst_chipselect", 64'(bus.m_chipselect), 64'd0);
    chk("midrst_write_n",    64'(bus.m_write_n),    64'd1);
    chk("midrst_address",    64'(bus.m_address),    64'd0);
    chk("midrst_rsp_valid",  64'(bus.rsp_valid),    64'd0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (12) step();
    chk("midrst_no_rsp", 64'(rsp_log.size()), 64'd0);
    chk("midrst_ready",  64'(bus.cmd_ready),  64'd1);
    wr_log.delete();
    run_cmd(3'd4, 64'h0, 2'b00, 3, 64'h0, 1'b0);                            // STATUS after reset

    // irq rising during SNAP
    snap_src = 64'hCAFE_0000_BEEF_0001;
    issue(3'd3, 64'h0, 2'b00, a);
    exp_rsp.push_back('{a + 10, 64'hCAFE_0000_BEEF_0001, 1'b0});
    push_exp_writes(3'd3, 64'h0, 2'b00, a);
`ifdef TIMER_HOST_AUTO_CLEAR_EN
    exp_wr.push_back('{a + 11, 4'd0, 16'h0000});
`endif
    for (int i = 0; i < 20 && cyc < a + 4; i++) step();
    irq_in = 1'b1;
    wait_rsp();
    check_rsp();
    chk("irq_ready_in_resp", 64'(bus.cmd_ready), 64'd0);
    step();
`ifdef TIMER_HOST_AUTO_CLEAR_EN
    chk("autoclr_ready_low", 64'(bus.cmd_ready), 64'd0);
    chk("autoclr_addr",      64'(bus.m_address), 64'd0);
    chk("autoclr_write",     64'({bus.m_chipselect, bus.m_write_n}), 64'b10);
    step();
    chk("autoclr_ready_back", 64'(bus.cmd_ready), 64'd1);
`else
    chk("irq_ready_after", 64'(bus.cmd_ready), 64'd1);
    step();
`endif
    irq_in = 1'b0;
    step();
    check_writes();
    chk("tp_count", 64'(tp_log.size()), 64'd1);
    if (tp_log.size() != 0) chk("tp_cycle", 64'(tp_log[0]), 64'(a + 5));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
